// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial WIDTH-bit adder controller. One 1-bit full-adder cell is reused
// LSB-first over WIDTH cycles with a registered carry. Operands and carry-in
// are captured on an accepted start. The result is held in sum/cout until the
// next operation completes, and done pulses for one cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle completion pulse
//   sum    out  WIDTH-bit result register (last completed result)
//   cout   out  carry-out register (last completed result)
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_ps;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_c_nxt;
  logic [WIDTH-1:0] w_ps_nxt;
  logic             w_last;

  // Shared full-adder cell on the current LSBs
  always_comb begin
    w_s      = r_a[0] ^ r_b[0] ^ r_c;
    w_c_nxt  = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    // After WIDTH shifts bit 0 of the result has reached the LSB
    w_ps_nxt = {w_s, r_ps[WIDTH-1:1]};
    w_last   = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_ps   <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= cin;
            r_ps  <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c_nxt;
          r_ps  <= w_ps_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= w_ps_nxt;
            r_cout <= w_c_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl at WIDTH=8. Expected results come
// from plain arithmetic ({cout,sum} = a+b+cin) and expected timing from the
// accept/latency/issue-interval rules of the block.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NRND  = 1000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int               n_checks;
  int               n_fail;
  logic [WIDTH:0]   last_res;

  serial_adder_ctrl #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c);
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
  endfunction

  // One operation from an idle block: latency, busy length, result hold and
  // final result are all checked.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc);
    logic [WIDTH:0] exp;
    int             lat;
    int             nbusy;
    bit             held_ok;
    exp = ref_add(ta, tb, tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    lat = 0; nbusy = 0; held_ok = 1'b1;
    while (!done && lat < 4 * WIDTH) begin
      if (busy) nbusy++;
      if ({cout, sum} !== last_res) held_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(WIDTH));
    chk("busy_cycles", 32'(nbusy), 32'(WIDTH));
    chk("sum_held_while_busy", 32'(held_ok), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("result", 32'({cout, sum}), 32'(exp));
    last_res = exp;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("result_kept", 32'({cout, sum}), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int             ndone;
    int             first_done;
    int             second_done;
    logic [WIDTH:0] r1;
    logic [WIDTH:0] r2;
    int             issued;
    int             since;
    int             cyc;
    logic [WIDTH:0] q[$];

    n_checks = 0; n_fail = 0; last_res = '0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'({cout, sum}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h00, 8'h00, 1'b0);

    // Start while busy: second request ignored, then held start is accepted
    // once the block is idle again (E10).
    ndone = 0; first_done = -1; second_done = -1; r1 = '0; r2 = '0;
    for (int cyc_i = 0; cyc_i < 20; cyc_i++) begin
      if (cyc_i == 0) begin
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
      end else if (cyc_i >= 3 && cyc_i <= 10) begin
        start = 1'b1; a = 8'h10; b = 8'h10; cin = 1'b0;
      end else begin
        start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
      end
      @(negedge clk);
      if (cyc_i == 9)  chk("busy_idle_gap", 32'(busy), 32'd0);
      if (cyc_i == 10) chk("busy_after_E10", 32'(busy), 32'd1);
      if (done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = cyc_i; r1 = {cout, sum};
        end else begin
          second_done = cyc_i; r2 = {cout, sum};
        end
      end
    end
    chk("busy_start_ndone", 32'(ndone), 32'd2);
    chk("busy_start_done1_cycle", 32'(first_done), 32'd8);
    chk("busy_start_result1", 32'(r1), 32'(ref_add(8'h01, 8'h01, 1'b0)));
    chk("busy_start_done2_cycle", 32'(second_done), 32'd18);
    chk("busy_start_result2", 32'(r2), 32'(ref_add(8'h10, 8'h10, 1'b0)));
    last_res = r2;

    // Reset in the middle of an operation
    start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_result", 32'({cout, sum}), 32'd0);
    last_res = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_reset", 32'(ndone), 32'd0);
    run_op(8'h03, 8'h04, 1'b0);

    // Random back-to-back regression with start held high
    issued = 0; since = 100; cyc = 0;
    while ((issued < int'(NRND) || q.size() > 0) &&
           cyc < int'(NRND * (WIDTH + 2)) + 100) begin
      start = (issued < int'(NRND));
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      if (start && since >= int'(WIDTH + 1)) begin
        q.push_back(ref_add(a, b, cin));
        issued++;
        since = 0;
      end else begin
        since++;
      end
      @(negedge clk);
      cyc++;
      chk("rnd_done_timing", 32'(done), 32'(since == int'(WIDTH)));
      if (since == int'(WIDTH) && q.size() > 0) begin
        chk("rnd_result", 32'({cout, sum}), 32'(q.pop_front()));
      end
    end
    start = 1'b0;
    chk("rnd_issued", 32'(issued), 32'(NRND));
    chk("rnd_queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
